// File: rtl/booth_mult_core_if.sv
// Handshake and operand bundle between the BIST tester (or functional
// source) and the sequential Booth multiplier core.
interface booth_mult_core_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic                 test_mode;
  logic [2*WIDTH-1:0]   pattern;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   prod;
  logic                 busy;
  logic                 done;

  // Tester / operand source side
  modport master (
    output start, test_mode, pattern, a, b,
    input  prod, busy, done
  );

  // Multiplier core side
  modport slave (
    input  start, test_mode, pattern, a, b,
    output prod, busy, done
  );
endinterface

// File: rtl/booth_mult_core.sv
// Sequential radix-2 Booth signed multiplier. One Booth step per clock,
// WIDTH steps per product. The accumulator carries one extra bit so that
// subtracting the most negative multiplicand cannot overflow.
module booth_mult_core #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  booth_mult_core_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state, state_nxt;
  logic signed [WIDTH:0]   acc, acc_nxt;
  logic signed [WIDTH:0]   m, m_nxt;
  logic [WIDTH-1:0]        q, q_nxt;
  logic                    q_m1, q_m1_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [2*WIDTH-1:0]      prod, prod_nxt;
  logic                    busy, busy_nxt;
  logic                    done, done_nxt;

  logic signed [WIDTH-1:0] mcand;
  logic [WIDTH-1:0]        mplier;
  logic signed [WIDTH:0]   acc_sum;

  // Booth recoding of the {Q0, Q-1} pair: add, subtract or keep, mod 2^(WIDTH+1)
  function automatic logic signed [WIDTH:0] booth_add(
    input logic signed [WIDTH:0] acc_in,
    input logic signed [WIDTH:0] m_in,
    input logic [1:0]            pair
  );
    case (pair)
      2'b01:   return acc_in + m_in;
      2'b10:   return acc_in - m_in;
      default: return acc_in;
    endcase
  endfunction

  // Operand source select; only meaningful on the accepting start edge
  always_comb begin
    mcand  = bus.test_mode ? bus.pattern[2*WIDTH-1:WIDTH] : bus.a;
    mplier = bus.test_mode ? bus.pattern[WIDTH-1:0]       : bus.b;
  end

  // Accumulator after the add/subtract, before the arithmetic shift
  always_comb begin
    acc_sum = booth_add(acc, m, {q[0], q_m1});
  end

  // Next-state and datapath update; start is ignored while in RUN
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    m_nxt     = m;
    q_nxt     = q;
    q_m1_nxt  = q_m1;
    cnt_nxt   = cnt;
    prod_nxt  = prod;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (bus.start) begin
          m_nxt     = {mcand[WIDTH-1], mcand};
          q_nxt     = mplier;
          acc_nxt   = '0;
          q_m1_nxt  = 1'b0;
          cnt_nxt   = CNT_W'(WIDTH);
          state_nxt = RUN;
          busy_nxt  = 1'b1;
        end
      end
      RUN: begin
        // Arithmetic right shift of {ACC, Q, Q-1}: ACC sign is replicated
        acc_nxt  = {acc_sum[WIDTH], acc_sum[WIDTH:1]};
        q_nxt    = {acc_sum[0], q[WIDTH-1:1]};
        q_m1_nxt = q[0];
        cnt_nxt  = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          // Low 2*WIDTH bits of the shifted {ACC, Q}
          prod_nxt  = {acc_sum, q[WIDTH-1:1]};
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any operation and clears the product
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      m     <= m_nxt;
      q     <= q_nxt;
      q_m1  <= q_m1_nxt;
      cnt   <= cnt_nxt;
      prod  <= prod_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  assign bus.prod = prod;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_booth_mult_core.sv
// Randomized and directed bench for booth_mult_core. A cycle-level
// behavioural model decides which starts are accepted and pushes the
// expected signed product into a scoreboard; a monitor on the falling
// edge checks busy/done/prod and pops the scoreboard on every done.
module tb_booth_mult_core;

  localparam int W = 4;

  logic clk;
  logic reset;

  booth_mult_core_if #(.WIDTH(W)) bus ();

  booth_mult_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  logic [2*W-1:0] sb_q[$];
  int             model_rem  = 0;
  logic [2*W-1:0] model_pend = '0;
  logic [2*W-1:0] model_prod = '0;
  logic           model_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [W-1:0] xs, ys;
    int p;
    logic [31:0] pv;
    xs = x;
    ys = y;
    p  = int'(xs) * int'(ys);
    pv = p;
    return pv[2*W-1:0];
  endfunction

  // Behavioural model: an accepted start yields a product WIDTH edges later
  initial begin
    forever begin
      @(posedge clk);
      model_done = 1'b0;
      if (reset) begin
        model_rem  = 0;
        model_prod = '0;
        sb_q.delete();
      end else if (model_rem == 0) begin
        if (bus.start) begin
          if (bus.test_mode)
            model_pend = ref_mul(bus.pattern[2*W-1:W], bus.pattern[W-1:0]);
          else
            model_pend = ref_mul(bus.a, bus.b);
          sb_q.push_back(model_pend);
          model_rem = W;
        end
      end else begin
        model_rem--;
        if (model_rem == 0) begin
          model_prod = model_pend;
          model_done = 1'b1;
        end
      end
    end
  end

  // Monitor: away from the active edge, compare outputs with the model
  initial begin
    logic [2*W-1:0] exp_p;
    forever begin
      @(negedge clk);
      check("busy", 32'(bus.busy), 32'(model_rem > 0));
      check("done", 32'(bus.done), 32'(model_done));
      check("prod_hold", 32'(bus.prod), 32'(model_prod));
      if (bus.done === 1'b1) begin
        done_seen++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'(1), 32'(0));
        end else begin
          exp_p = sb_q.pop_front();
          check("scoreboard_prod", 32'(bus.prod), 32'(exp_p));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic tm, input logic [2*W-1:0] pat,
                        input logic [W-1:0] aa, input logic [W-1:0] bb);
    bus.start     = s;
    bus.test_mode = tm;
    bus.pattern   = pat;
    bus.a         = aa;
    bus.b         = bb;
  endtask

  // One start pulse, then wait past completion and check the held product
  task automatic run_op(input string name, input logic tm, input logic [2*W-1:0] pat,
                        input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic [2*W-1:0] exp);
    set_in(1'b1, tm, pat, aa, bb);
    step(1);
    bus.start = 1'b0;
    step(W + 2);
    check(name, 32'(bus.prod), 32'(exp));
  endtask

  initial begin
    int d0;
    reset = 1'b1;
    set_in(1'b0, 1'b1, 8'h00, 4'h0, 4'h0);
    step(2);
    check("reset_prod", 32'(bus.prod), 32'(0));
    check("reset_busy", 32'(bus.busy), 32'(0));
    check("reset_done", 32'(bus.done), 32'(0));
    reset = 1'b0;
    step(1);

    // Basic multiply with busy window length
    set_in(1'b1, 1'b1, 8'h35, 4'h0, 4'h0);
    step(1);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("busy_window", 32'(bus.busy), 32'(1));
      step(1);
    end
    check("basic_done", 32'(bus.done), 32'(1));
    check("basic_prod", 32'(bus.prod), 32'h0F);
    step(3);
    check("basic_hold", 32'(bus.prod), 32'h0F);

    // Signed corners and operand source
    run_op("neg8_neg8", 1'b1, 8'h88, 4'h0, 4'h0, 8'h40);
    run_op("7_neg8",    1'b1, 8'h78, 4'h0, 4'h0, 8'hC8);
    run_op("neg3_7",    1'b1, 8'hD7, 4'h0, 4'h0, 8'hEB);
    run_op("zero",      1'b1, 8'h00, 4'h0, 4'h0, 8'h00);
    run_op("func_src",  1'b0, 8'h35, 4'hF, 4'h6, 8'hFA);

    // Start while busy, including on the completion edge
    d0 = done_seen;
    set_in(1'b1, 1'b1, 8'h23, 4'h0, 4'h0);
    step(1);
    bus.start = 1'b0;
    step(1);
    set_in(1'b1, 1'b1, 8'h77, 4'h0, 4'h0);
    step(1);
    bus.start = 1'b0;
    step(1);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    step(3);
    check("busy_start_prod", 32'(bus.prod), 32'h06);
    check("busy_start_dones", 32'(done_seen - d0), 32'(1));

    // Held start: completions every WIDTH+1 cycles
    d0 = done_seen;
    set_in(1'b1, 1'b1, 8'h35, 4'h0, 4'h0);
    step(3 * (W + 1));
    bus.start = 1'b0;
    step(W + 2);
    check("held_start_dones", 32'(done_seen - d0), 32'(3));

    // Reset in busy cycle 2
    set_in(1'b1, 1'b1, 8'h77, 4'h0, 4'h0);
    step(1);
    bus.start = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_mid_busy", 32'(bus.busy), 32'(0));
    check("rst_mid_done", 32'(bus.done), 32'(0));
    check("rst_mid_prod", 32'(bus.prod), 32'(0));
    step(W + 1);
    check("rst_mid_nodone", 32'(bus.prod), 32'(0));
    run_op("after_rst", 1'b1, 8'h77, 4'h0, 4'h0, 8'h31);

    // Operand hold while busy
    set_in(1'b1, 1'b1, 8'h35, 4'h0, 4'h0);
    step(1);
    set_in(1'b0, 1'b1, 8'hFF, 4'h0, 4'h0);
    step(W + 1);
    check("operand_hold", 32'(bus.prod), 32'h0F);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 2) == 0, 1'($urandom), 8'($urandom),
             4'($urandom), 4'($urandom));
      reset = ($urandom_range(0, 79) == 0);
      step(1);
    end
    reset = 1'b0;
    bus.start = 1'b0;
    step(W + 3);
    check("scoreboard_drain", 32'(sb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
